// File: rtl/wca_phase_hop_seq_pkg.sv
// Shared widths, FSM encodings and hop-table entry layout for the WCA frequency-hop sequencer.
package wca_phase_hop_seq_pkg;

  localparam int unsigned RESOLUTION  = 32;
  localparam int unsigned DEPTH_LOG2  = 3;
  localparam int unsigned DWELL_WIDTH = 16;
  localparam int unsigned DEPTH       = 1 << DEPTH_LOG2;
  localparam int unsigned DWELL_MIN   = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DWELL = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic [RESOLUTION-1:0]  freq;
    logic [DWELL_WIDTH-1:0] dwell;
  } hop_entry_t;

  // A zero dwell would never terminate, so it is promoted to the minimum.
  function automatic logic [DWELL_WIDTH-1:0] dwell_eff(input logic [DWELL_WIDTH-1:0] d);
    return (d < DWELL_WIDTH'(DWELL_MIN)) ? DWELL_WIDTH'(DWELL_MIN) : d;
  endfunction

endpackage

// File: rtl/wca_phase_hop_seq_if.sv
// Control/table/accumulator bundle of the hop sequencer; master = rbus config side, slave = sequencer.
interface wca_phase_hop_seq_if;
  import wca_phase_hop_seq_pkg::*;

  logic                   enable;
  logic                   strobe;
  logic                   start;
  logic                   abort;
  logic                   loop_mode;
  logic                   clr_on_hop;
  logic [DEPTH_LOG2-1:0]  num_hops;
  logic                   tbl_we;
  logic [DEPTH_LOG2-1:0]  tbl_addr;
  logic [RESOLUTION-1:0]  tbl_freq;
  logic [DWELL_WIDTH-1:0] tbl_dwell;
  logic [RESOLUTION-1:0]  freq;
  logic                   acc_strobe;
  logic                   acc_aclr;
  logic [DEPTH_LOG2-1:0]  hop_index;
  logic                   hop_pulse;
  logic                   busy;
  logic                   done;

  modport master (
    output enable, strobe, start, abort, loop_mode, clr_on_hop, num_hops,
           tbl_we, tbl_addr, tbl_freq, tbl_dwell,
    input  freq, acc_strobe, acc_aclr, hop_index, hop_pulse, busy, done
  );

  modport slave (
    input  enable, strobe, start, abort, loop_mode, clr_on_hop, num_hops,
           tbl_we, tbl_addr, tbl_freq, tbl_dwell,
    output freq, acc_strobe, acc_aclr, hop_index, hop_pulse, busy, done
  );

endinterface

// File: rtl/wca_hop_table.sv
// Hop table RAM: one write port, one synchronous read port, write-first on address collision.
module wca_hop_table
  import wca_phase_hop_seq_pkg::*;
(
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  hop_entry_t            wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output hop_entry_t            rdata
);

  hop_entry_t mem [DEPTH];

  // Storage is deliberately left unreset; contents are defined only once written.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/wca_phase_hop_seq.sv
// Frequency-hop sequencer: walks the hop table, drives freq and gates sample strobes for each dwell.
module wca_phase_hop_seq
  import wca_phase_hop_seq_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  wca_phase_hop_seq_if.slave bus
);

  logic [1:0]             state_q, state_d;
  logic [DEPTH_LOG2-1:0]  idx_q, idx_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic                   first_q, first_d;
  logic                   pend_q, pend_d;
  logic [RESOLUTION-1:0]  freq_q, freq_d;
  logic [DEPTH_LOG2-1:0]  hop_index_q, hop_index_d;
  logic                   acc_strobe_q, acc_strobe_d;
  logic                   acc_aclr_q, acc_aclr_d;
  logic                   hop_pulse_q, hop_pulse_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   hit;
  logic                   last;
  logic [DWELL_WIDTH-1:0] cnt_cur;
  logic [DWELL_WIDTH-1:0] cnt_dec;
  hop_entry_t             wr_entry;
  hop_entry_t             rd_entry;

  assign wr_entry.freq  = bus.tbl_freq;
  assign wr_entry.dwell = bus.tbl_dwell;

  wca_hop_table u_table (
    .clock (clock),
    .we    (bus.tbl_we),
    .waddr (bus.tbl_addr),
    .wdata (wr_entry),
    .raddr (idx_q),
    .rdata (rd_entry)
  );

  // Next state and registered-output values.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    first_d      = 1'b0;
    pend_d       = 1'b0;
    freq_d       = freq_q;
    hop_index_d  = hop_index_q;
    acc_strobe_d = 1'b0;
    acc_aclr_d   = 1'b0;
    hop_pulse_d  = 1'b0;
    done_d       = 1'b0;
    hit          = bus.strobe & bus.enable;
    last         = (idx_q >= bus.num_hops);
    cnt_cur      = cnt_q;
    cnt_dec      = '0;

    if (bus.abort) begin
      state_d    = ST_IDLE;
      acc_aclr_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d    = ST_LOAD;
            idx_d      = '0;
            acc_aclr_d = bus.clr_on_hop;
          end
        end
        ST_LOAD: begin
          state_d = ST_DWELL;
          first_d = 1'b1;
          pend_d  = hit;
        end
        ST_DWELL: begin
          // Entry cycle: present the new word and absorb a strobe held over from LOAD.
          if (first_q) begin
            freq_d      = rd_entry.freq;
            hop_index_d = idx_q;
            hop_pulse_d = 1'b1;
            cnt_cur     = dwell_eff(rd_entry.dwell);
            hit         = hit | pend_q;
          end
          cnt_dec = DWELL_WIDTH'(cnt_cur - 1'b1);
          cnt_d   = cnt_cur;
          if (hit) begin
            acc_strobe_d = 1'b1;
            cnt_d        = cnt_dec;
            if (cnt_dec == '0) begin
              if (last && !bus.loop_mode) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                state_d    = ST_LOAD;
                idx_d      = last ? '0 : DEPTH_LOG2'(idx_q + 1'b1);
                acc_aclr_d = bus.clr_on_hop;
              end
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_LOAD) || (state_d == ST_DWELL);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      first_q      <= 1'b0;
      pend_q       <= 1'b0;
      freq_q       <= '0;
      hop_index_q  <= '0;
      acc_strobe_q <= 1'b0;
      acc_aclr_q   <= 1'b0;
      hop_pulse_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      pend_q       <= pend_d;
      freq_q       <= freq_d;
      hop_index_q  <= hop_index_d;
      acc_strobe_q <= acc_strobe_d;
      acc_aclr_q   <= acc_aclr_d;
      hop_pulse_q  <= hop_pulse_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.freq       = freq_q;
  assign bus.acc_strobe = acc_strobe_q;
  assign bus.acc_aclr   = acc_aclr_q;
  assign bus.hop_index  = hop_index_q;
  assign bus.hop_pulse  = hop_pulse_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
